pwm_duty_ramp: RTL

- Upstream stage of the Enhanced PWM. Drives its duty input (R+1 bits, full scale 2^R = 100 %).
- Generates soft-start/soft-stop ramps: duty moves one LSB per programmable interval toward a loaded target.
- Optional breathe mode ramps continuously between 0 and the target.
- duty output connects directly to the PWM duty port.

---
 rtl/pwm_duty_ramp.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pwm_duty_ramp.sv
// Soft-start / soft-stop duty ramp generator feeding the Enhanced PWM duty port.
// Moves duty one LSB per programmable interval toward a loaded target, with an optional breathe mode.
module pwm_duty_ramp #(
  parameter int R         = 5,
  parameter int STEP_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 load,
  input  logic [R:0]           target,
  input  logic [STEP_BITS-1:0] step_interval,
  input  logic                 breathe,
  output logic [R:0]           duty,
  output logic                 busy,
  output logic                 done
);

  localparam logic [R:0] FULL_SCALE = {1'b1, {R{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } state_e;

  state_e               state_q, state_d;
  logic [R:0]           duty_q, duty_d;
  logic [R:0]           tgt_q, tgt_d;
  logic [STEP_BITS-1:0] int_q, int_d;
  logic [STEP_BITS-1:0] timer_q, timer_d;
  logic                 brth_q, brth_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [R:0]           tgt_sat;
  logic [R:0]           end_pt;

  // NOTE: every signal gets its default before any branch, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    int_d   = int_q;
    timer_d = timer_q;
    brth_d  = brth_q;
    done_d  = 1'b0;

    tgt_sat = (target > FULL_SCALE) ? FULL_SCALE : target;
    // A breathing ramp always falls all the way to zero before turning around.
    end_pt  = (state_q == RAMP_DOWN && brth_q) ? '0 : tgt_q;

    if (load) begin
      tgt_d   = tgt_sat;
      int_d   = step_interval;
      brth_d  = breathe;
      timer_d = '0;
      if (tgt_sat > duty_q) begin
        state_d = RAMP_UP;
      end else if (tgt_sat < duty_q) begin
        state_d = RAMP_DOWN;
      end else if (!breathe) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (tgt_sat == '0) begin
        state_d = IDLE;
      end else begin
        state_d = RAMP_DOWN;
      end
    end else if (enable && state_q != IDLE) begin
      if (timer_q != int_q) begin
        timer_d = timer_q + 1'b1;
      end else begin
        timer_d = '0;
        // Compare before stepping so duty can never pass the end point or wrap.
        if (state_q == RAMP_UP && duty_q < end_pt) begin
          duty_d = duty_q + 1'b1;
        end else if (state_q == RAMP_DOWN && duty_q > end_pt) begin
          duty_d = duty_q - 1'b1;
        end
        if (duty_d == end_pt) begin
          if (!brth_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (state_q == RAMP_UP) begin
            state_d = RAMP_DOWN;
          end else begin
            state_d = RAMP_UP;
          end
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      int_q   <= '0;
      timer_q <= '0;
      brth_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      int_q   <= int_d;
      timer_q <= timer_d;
      brth_q  <= brth_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign duty = duty_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
